// File: rtl/nibble_packer.sv
// Pops 4-bit nibbles from a queue tail and packs NIBBLES of them little-endian into one word.
// The word is presented on a valid/ready output. Define NIBBLE_PACKER_FLUSH_EN to add flush_i for partial words.
module nibble_packer #(
  parameter int NIBBLES = 8,
  parameter int CNT_W   = $clog2(NIBBLES + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   q_empty_i,
  input  logic [3:0]             q_data_i,
  output logic                   q_pop_o,
`ifdef NIBBLE_PACKER_FLUSH_EN
  input  logic                   flush_i,
`endif
  output logic [4*NIBBLES-1:0]   word_o,
  output logic                   word_valid_o,
  input  logic                   word_ready_i,
  output logic [CNT_W-1:0]       word_nibbles_o
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     nib_q, nib_d;
  logic [4*NIBBLES-1:0] word_q, word_d;
  logic [4*NIBBLES-1:0] word_fill;
  logic                 pop;
  logic                 flush_req;
  logic                 last_nibble;

`ifdef NIBBLE_PACKER_FLUSH_EN
  assign flush_req = flush_i;
`else
  assign flush_req = 1'b0;
`endif

  assign last_nibble = (cnt_q == CNT_W'(NIBBLES - 1));

  // Each lane captures the tail nibble only when the counter points at it.
  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_lane
    assign word_fill[4*gi +: 4] = (pop && (cnt_q == CNT_W'(gi))) ? q_data_i
                                                                 : word_q[4*gi +: 4];
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    nib_d        = nib_q;
    word_d       = word_q;
    pop          = 1'b0;
    word_valid_o = 1'b0;
    case (state_q)
      FILL: begin
        // Pop never looks at downstream ready or flush, so there is no ready->pop path.
        pop    = ~q_empty_i;
        word_d = word_fill;
        if (pop) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (pop && last_nibble) begin
          state_d = HOLD;
          cnt_d   = '0;
          nib_d   = CNT_W'(NIBBLES);
        end else if (flush_req && ((cnt_q != '0) || pop)) begin
          state_d = HOLD;
          cnt_d   = '0;
          nib_d   = cnt_q + CNT_W'(pop);
        end
      end
      HOLD: begin
        word_valid_o = 1'b1;
        if (word_ready_i) begin
          // Clearing here keeps unfilled lanes of the next word at zero.
          state_d = FILL;
          word_d  = '0;
          nib_d   = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FILL;
      cnt_q   <= '0;
      nib_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nib_q   <= nib_d;
      word_q  <= word_d;
    end
  end

  assign q_pop_o        = pop;
  assign word_o         = word_q;
  assign word_nibbles_o = nib_q;

endmodule

// File: tb/tb_nibble_packer.sv
// Directed bench for nibble_packer (NIBBLES=8) with a behavioural queue in front of it.
// Flush scenarios run only when NIBBLE_PACKER_FLUSH_EN is defined.
module tb_nibble_packer;

  localparam int NIBBLES = 8;
  localparam int CNT_W   = $clog2(NIBBLES + 1);

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 q_empty_i;
  logic [3:0]           q_data_i;
  logic                 q_pop_o;
  logic                 flush_i;
  logic [4*NIBBLES-1:0] word_o;
  logic                 word_valid_o;
  logic                 word_ready_i;
  logic [CNT_W-1:0]     word_nibbles_o;

  logic [3:0] fifo[$];
  logic       pop_seen;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk_i = ~clk_i;

  nibble_packer #(.NIBBLES(NIBBLES)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .q_empty_i      (q_empty_i),
    .q_data_i       (q_data_i),
    .q_pop_o        (q_pop_o),
`ifdef NIBBLE_PACKER_FLUSH_EN
    .flush_i        (flush_i),
`endif
    .word_o         (word_o),
    .word_valid_o   (word_valid_o),
    .word_ready_i   (word_ready_i),
    .word_nibbles_o (word_nibbles_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // One clock cycle starting and ending at the falling edge; the queue pops when q_pop_o was high.
  task automatic step();
    q_empty_i = (fifo.size() == 0);
    q_data_i  = (fifo.size() == 0) ? 4'h0 : fifo[0];
    #1;
    pop_seen = q_pop_o;
    @(posedge clk_i);
    if (pop_seen && fifo.size() != 0) void'(fifo.pop_front());
    @(negedge clk_i);
  endtask

  task automatic push(input logic [3:0] v);
    fifo.push_back(v);
  endtask

  initial begin
    logic [31:0] held;
    rst_i        = 1'b1;
    flush_i      = 1'b0;
    word_ready_i = 1'b1;
    q_empty_i    = 1'b1;
    q_data_i     = 4'h0;
    @(negedge clk_i);
    step();
    step();
    rst_i = 1'b0;
    check("rst_valid", 64'(word_valid_o), 64'd0);
    check("rst_word", 64'(word_o), 64'd0);
    check("rst_nibbles", 64'(word_nibbles_o), 64'd0);
    step();
    check("rst_pop_empty", 64'(pop_seen), 64'd0);

    // Full word 1..8 with ready high
    for (int i = 1; i <= 8; i++) push(4'(i));
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("full_pop%0d", i), 64'(pop_seen), 64'd1);
      if (i == 7) check("full_valid_early", 64'(word_valid_o), 64'd0);
    end
    check("full_valid", 64'(word_valid_o), 64'd1);
    check("full_word", 64'(word_o), 64'h87654321);
    check("full_nibbles", 64'(word_nibbles_o), 64'd8);
    step();
    check("full_hs_nopop", 64'(pop_seen), 64'd0);
    check("full_hs_valid", 64'(word_valid_o), 64'd0);
    check("full_hs_word", 64'(word_o), 64'd0);

    // Backpressure: word pending with ready low for 5 cycles
    word_ready_i = 1'b0;
    for (int i = 1; i <= 8; i++) push(4'(i));
    push(4'h9);
    for (int i = 1; i <= 8; i++) step();
    check("bp_valid", 64'(word_valid_o), 64'd1);
    held = word_o;
    check("bp_word", 64'(held), 64'h87654321);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("bp_nopop%0d", i), 64'(pop_seen), 64'd0);
      check($sformatf("bp_valid%0d", i), 64'(word_valid_o), 64'd1);
      check($sformatf("bp_word%0d", i), 64'(word_o), 64'h87654321);
    end
    word_ready_i = 1'b1;
    step();
    check("bp_hs_nopop", 64'(pop_seen), 64'd0);
    check("bp_hs_valid", 64'(word_valid_o), 64'd0);
    step();
    check("bp_next_pop", 64'(pop_seen), 64'd1);
    check("bp_next_word", 64'(word_o), 64'h00000009);

    // Reset mid-fill after 5 pops (9 plus four more)
    for (int i = 0; i < 4; i++) push(4'hE);
    for (int i = 0; i < 4; i++) step();
    check("mid_word", 64'(word_o), 64'h000EEEE9);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("mrst_valid", 64'(word_valid_o), 64'd0);
    check("mrst_word", 64'(word_o), 64'd0);
    check("mrst_nibbles", 64'(word_nibbles_o), 64'd0);
    for (int i = 8; i >= 1; i--) push(4'(i));
    for (int i = 0; i < 8; i++) step();
    check("mrst_fresh_valid", 64'(word_valid_o), 64'd1);
    check("mrst_fresh_word", 64'(word_o), 64'h12345678);
    check("mrst_fresh_nib", 64'(word_nibbles_o), 64'd8);
    step();

    // Starvation: A, B, ten empty cycles, then six F
    push(4'hA);
    push(4'hB);
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("starve_nopop%0d", i), 64'(pop_seen), 64'd0);
    end
    check("starve_valid", 64'(word_valid_o), 64'd0);
    check("starve_partial", 64'(word_o), 64'h000000BA);
    for (int i = 0; i < 6; i++) push(4'hF);
    for (int i = 0; i < 6; i++) step();
    check("starve_valid_end", 64'(word_valid_o), 64'd1);
    check("starve_word", 64'(word_o), 64'hFFFFFFBA);
    step();

`ifdef NIBBLE_PACKER_FLUSH_EN
    // Flush a three-nibble partial word with the queue empty
    push(4'hA);
    push(4'hB);
    push(4'hC);
    for (int i = 0; i < 3; i++) step();
    word_ready_i = 1'b0;
    flush_i      = 1'b1;
    step();
    flush_i = 1'b0;
    check("flush_valid", 64'(word_valid_o), 64'd1);
    check("flush_word", 64'(word_o), 64'h00000CBA);
    check("flush_nibbles", 64'(word_nibbles_o), 64'd3);
    word_ready_i = 1'b1;
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("flush_empty_ignored", 64'(word_valid_o), 64'd0);

    // Flush together with the second pop
    push(4'h1);
    push(4'h2);
    word_ready_i = 1'b0;
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("flushpop_valid", 64'(word_valid_o), 64'd1);
    check("flushpop_word", 64'(word_o), 64'h00000021);
    check("flushpop_nibbles", 64'(word_nibbles_o), 64'd2);
    word_ready_i = 1'b1;
    step();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
